// File: rtl/pad_serializer.sv
// Pad-side serializer: captures a parallel word on valid/ready and shifts it out
// MSB-first on a three-wire SPI mode-0 link. Every pad-facing output is a flop.
module pad_serializer #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              sclk_o,
   output logic              sdo_o,
   output logic              cs_no,
   output logic              busy_o,
   output logic              frame_done_o
);

   // state | meaning
   // IDLE  | no frame; ready_o high, waiting for valid_i
   // LOW   | sclk low half of a bit; sdo_o holds the current bit
   // HIGH  | sclk high half of a bit; the receiver samples on entry
   // GAP   | cs_no released, recovery time before the next accept

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      GAP
   } state_t;

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div_cnt, div_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_nxt;
   logic [DATA_W-1:0] shift_q, shift_nxt;
   logic              sclk_nxt, sdo_nxt, cs_nxt, done_nxt, ready_nxt;
   logic              div_tc;

   assign div_tc = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift_q;
      sclk_nxt  = sclk_o;
      sdo_nxt   = sdo_o;
      cs_nxt    = cs_no;
      done_nxt  = 1'b0;
      ready_nxt = ready_o;

      case (state)
         IDLE: begin
            if (valid_i && ready_o) begin
               state_nxt = LOW;
               shift_nxt = data_i;
               sdo_nxt   = data_i[DATA_W-1];
               cs_nxt    = 1'b0;
               div_nxt   = '0;
               bit_nxt   = '0;
               ready_nxt = 1'b0;
            end
         end

         LOW: begin
            if (div_tc) begin
               state_nxt = HIGH;
               sclk_nxt  = 1'b1;
               div_nxt   = '0;
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end

         HIGH: begin
            if (div_tc) begin
               sclk_nxt = 1'b0;
               div_nxt  = '0;
               if (bit_cnt == BIT_LAST) begin
                  // last bit done: release the frame together with the falling sclk
                  state_nxt = GAP;
                  cs_nxt    = 1'b1;
                  sdo_nxt   = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = LOW;
                  sdo_nxt   = shift_q[DATA_W-2];
                  shift_nxt = {shift_q[DATA_W-2:0], 1'b0};
                  bit_nxt   = bit_cnt + 1'b1;
               end
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end

         GAP: begin
            if (div_tc) begin
               state_nxt = IDLE;
               ready_nxt = 1'b1;
               div_nxt   = '0;
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
            cs_nxt    = 1'b1;
            sclk_nxt  = 1'b0;
            sdo_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state        <= IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         shift_q      <= '0;
         sclk_o       <= 1'b0;
         sdo_o        <= 1'b0;
         cs_no        <= 1'b1;
         frame_done_o <= 1'b0;
         ready_o      <= 1'b1;
         busy_o       <= 1'b0;
      end else begin
         state        <= state_nxt;
         div_cnt      <= div_nxt;
         bit_cnt      <= bit_nxt;
         shift_q      <= shift_nxt;
         sclk_o       <= sclk_nxt;
         sdo_o        <= sdo_nxt;
         cs_no        <= cs_nxt;
         frame_done_o <= done_nxt;
         ready_o      <= ready_nxt;
         busy_o       <= ~ready_nxt;
      end
   end

endmodule

// File: tb/tb_pad_serializer.sv
// Bench for pad_serializer: two instances (16b/div4 and 8b/div1) checked every cycle
// against a frame-offset timing model, plus a serial decoder and literal spot checks.
module tb_pad_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, valid_a, ready_a, sclk_a, sdo_a, cs_a, busy_a, done_a;
   logic [15:0] data_a;
   logic        rst_b, valid_b, ready_b, sclk_b, sdo_b, cs_b, busy_b, done_b;
   logic [7:0]  data_b;

   pad_serializer #(.DATA_W(16), .CLK_DIV(4)) dut_a (
      .clk_i(clk), .rst_ni(rst_a), .data_i(data_a), .valid_i(valid_a), .ready_o(ready_a),
      .sclk_o(sclk_a), .sdo_o(sdo_a), .cs_no(cs_a), .busy_o(busy_a), .frame_done_o(done_a));

   pad_serializer #(.DATA_W(8), .CLK_DIV(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_b), .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b),
      .sclk_o(sclk_b), .sdo_o(sdo_b), .cs_no(cs_b), .busy_o(busy_b), .frame_done_o(done_b));

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int cyc    = 0;

   // model: frame described by accept time and cycle offset k since the accept edge
   bit          m_act [2];
   int          m_k   [2];
   logic [31:0] m_w   [2];
   int          acc_t [2];
   int          acc_prev [2];
   logic [31:0] exp_q [2][$];

   // serial decoder observing the pads
   logic [31:0] dec_q [2][$];
   logic [31:0] dec_w [2];
   int          rises [2], last_rises [2];
   int          cs_run [2], last_cs_low [2];
   int          done_run [2], last_done_w [2];
   logic        prev_sclk [2], prev_cs [2];

   // returns {ready, sclk, sdo, cs_n, done}
   function automatic logic [4:0] model_out(int dw, int cd, bit act, int k, logic [31:0] w);
      int f;
      f = 2 * cd * dw;
      if (!act || k >= f + cd) return 5'b10010;
      if (k < f) return {1'b0, (k % (2 * cd)) >= cd, w[dw - 1 - k / (2 * cd)], 1'b0, 1'b0};
      if (k == f) return 5'b00011;
      return 5'b00010;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor(int id, int dw, int cd, logic rst, logic valid, logic [31:0] data,
                          logic ready, logic busy, logic sclk, logic sdo, logic cs, logic done);
      logic [4:0] e, got;
      e   = model_out(dw, cd, m_act[id], m_k[id], m_w[id]);
      got = {ready, sclk, sdo, cs, done};
      if (chk_en) begin
         checks++;
         if (got !== e || busy !== ~e[4]) begin
            errors++;
            $display("FAIL pins[%0d] cycle %0d: got rdy/sclk/sdo/csn/done=%b busy=%b expected %b busy=%b",
                     id, cyc, got, busy, e, ~e[4]);
         end
         if (m_act[id] && m_k[id] == 2 * cd * dw) exp_q[id].push_back(m_w[id]);

         if (!cs && prev_cs[id]) begin
            dec_w[id] = '0;
            rises[id] = 0;
         end
         if (sclk && !prev_sclk[id] && !cs) begin
            dec_w[id] = {dec_w[id][30:0], sdo};
            rises[id]++;
         end
         if (!cs) cs_run[id]++;
         else if (cs_run[id] != 0) begin
            last_cs_low[id] = cs_run[id];
            cs_run[id] = 0;
         end
         if (done) begin
            dec_q[id].push_back(dec_w[id]);
            last_rises[id] = rises[id];
            done_run[id]++;
         end else if (done_run[id] != 0) begin
            last_done_w[id] = done_run[id];
            done_run[id] = 0;
         end
         prev_cs[id]   = cs;
         prev_sclk[id] = sclk;
      end
      // inputs seen here are the ones the next rising edge will sample
      if (!rst) m_act[id] = 1'b0;
      else if (e[4] && valid) begin
         m_act[id]    = 1'b1;
         m_k[id]      = 0;
         m_w[id]      = data;
         acc_prev[id] = acc_t[id];
         acc_t[id]    = cyc;
      end else if (m_act[id]) m_k[id]++;
   endtask

   always @(negedge clk) begin
      cyc++;
      monitor(0, 16, 4, rst_a, valid_a, {16'h0, data_a}, ready_a, busy_a, sclk_a, sdo_a, cs_a, done_a);
      monitor(1, 8, 1, rst_b, valid_b, {24'h0, data_b}, ready_b, busy_b, sclk_b, sdo_b, cs_b, done_b);
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_a(logic [15:0] w);
      valid_a = 1'b1;
      data_a  = w;
      step(1);
      valid_a = 1'b0;
      data_a  = 16'($urandom);
   endtask

   task automatic wait_ready(int id, int max, output int n);
      n = 0;
      while (n < max && !(id == 0 ? ready_a : ready_b)) begin
         step(1);
         n++;
      end
      checks++;
      if (!(id == 0 ? ready_a : ready_b)) begin
         errors++;
         $display("FAIL wait_ready[%0d]: ready_o still low after %0d cycles", id, max);
      end
   endtask

   task automatic drain(int id, string name);
      chk({name, " count"}, dec_q[id].size(), exp_q[id].size());
      while (dec_q[id].size() > 0 && exp_q[id].size() > 0)
         chk(name, dec_q[id].pop_front(), exp_q[id].pop_front());
      dec_q[id].delete();
      exp_q[id].delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] cnt0, cnt1;
      rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
      data_a = '0; data_b = '0;
      prev_cs   = '{1'b1, 1'b1};
      prev_sclk = '{1'b0, 1'b0};
      dec_w     = '{32'h0, 32'h0};
      m_w       = '{32'h0, 32'h0};
      step(2);
      chk_en = 1'b1;
      rst_a = 1'b1; rst_b = 1'b1;

      // idle after reset
      step(50);
      chk("idle ready", ready_a, 1);
      chk("idle csn", cs_a, 1);
      chk("idle sclk", sclk_a, 0);
      chk("idle sdo", sdo_a, 0);
      chk("idle done", done_a, 0);

      // single frame at defaults
      send_a(16'hA5C3);
      wait_ready(0, 300, n);
      chk("a5c3 ready latency", n, 132);
      chk("a5c3 csn low cycles", last_cs_low[0], 128);
      chk("a5c3 sclk rises", last_rises[0], 16);
      chk("a5c3 done width", last_done_w[0], 1);
      chk("a5c3 frames", dec_q[0].size(), 1);
      if (dec_q[0].size() > 0) chk("a5c3 word", dec_q[0][0], 32'hA5C3);
      drain(0, "a5c3 model");

      // back-to-back with valid held; data_i scrambled while busy
      valid_a = 1'b1;
      data_a  = 16'h0001;
      step(1);
      for (int i = 0; i < 140; i++) begin
         data_a = (i < 125) ? 16'($urandom) : 16'h8000;
         step(1);
      end
      valid_a = 1'b0;
      wait_ready(0, 400, n);
      chk("b2b accept gap", acc_t[0] - acc_prev[0], 133);
      chk("b2b frames", dec_q[0].size(), 2);
      if (dec_q[0].size() > 1) begin
         chk("b2b word0", dec_q[0][0], 32'h0001);
         chk("b2b word1", dec_q[0][1], 32'h8000);
      end
      drain(0, "b2b model");

      // reset 40 cycles into a frame
      send_a(16'hFFFF);
      step(39);
      rst_a = 1'b0;
      step(1);
      chk("rst ready", ready_a, 1);
      chk("rst csn", cs_a, 1);
      chk("rst sclk", sclk_a, 0);
      chk("rst sdo", sdo_a, 0);
      chk("rst done", done_a, 0);
      rst_a = 1'b1;
      step(2);
      chk("rst no frame", dec_q[0].size(), 0);
      send_a(16'h1234);
      wait_ready(0, 300, n);
      if (dec_q[0].size() > 0) chk("post-rst word", dec_q[0][0], 32'h1234);
      drain(0, "post-rst model");

      // CLK_DIV=1, DATA_W=8 instance
      valid_b = 1'b1;
      data_b  = 8'h96;
      step(1);
      valid_b = 1'b0;
      wait_ready(1, 50, n);
      chk("div1 ready latency", n, 17);
      step(2);
      chk("div1 csn low cycles", last_cs_low[1], 16);
      chk("div1 sclk rises", last_rises[1], 8);
      chk("div1 done width", last_done_w[1], 1);
      if (dec_q[1].size() > 0) chk("div1 word", dec_q[1][0], 32'h96);
      drain(1, "div1 model");

      // free-running counters on data_i with valid held
      cnt0 = 8'd0;
      cnt1 = 8'd0;
      valid_a = 1'b1;
      for (int i = 0; i < 450; i++) begin
         data_a = {cnt1, cnt0};
         step(1);
         cnt0 = cnt0 + 8'd1;
         cnt1 = cnt1 + 8'd7;
      end
      valid_a = 1'b0;
      wait_ready(0, 300, n);
      chk("counter frames", dec_q[0].size(), 4);
      if (dec_q[0].size() > 1) begin
         chk("counter word0", dec_q[0][0], 32'h0000);
         chk("counter word1", dec_q[0][1], 32'hA385);
      end
      drain(0, "counter model");

      // random traffic on both, with occasional resets on the fast instance
      for (int i = 0; i < 1500; i++) begin
         valid_a = ($urandom_range(0, 3) == 0);
         data_a  = 16'($urandom);
         valid_b = ($urandom_range(0, 2) == 0);
         data_b  = 8'($urandom);
         rst_b   = ($urandom_range(0, 199) != 0);
         step(1);
      end
      valid_a = 1'b0;
      valid_b = 1'b0;
      rst_b   = 1'b1;
      wait_ready(0, 300, n);
      wait_ready(1, 50, n);
      step(2);
      drain(0, "random a");
      drain(1, "random b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
